rr_arb_oh: RTL and testbench
============================

# rr_arb_oh

Round-robin arbiter that produces the one-hot select vector for the downstream one-hot data mux. It takes N valid/ready requesters and grants exactly one per cycle. It holds the grant stable across output back-pressure. Priority rotates past the last served requester. Grant output is combinational from the requests plus registered arbitration state, so mux select and data line up in the same cycle.

## Interface
- `N`, default 8: number of requesters; legal range 1..64.
- `IdxW`, default `$clog2(N)` (minimum 1): width of the encoded grant index.
- `clk` input, 1: single clock, rising edge.
- `rstn` input, 1: asynchronous active-low reset.
- `req_vld_i` input, N: per-requester valid.
- `req_last_i` input, N: per-requester end-of-packet flag. Used only when `RR_ARB_PKT_LOCK_EN` is defined.
- `req_rdy_o` output, N: per-requester ready; `req_rdy_o[i] = gnt_oh_o[i] & out_rdy_i`.
- `gnt_oh_o` output, N: one-hot grant. This drives the select input of the one-hot mux. All-zero when nothing is granted.
- `gnt_idx_o` output, IdxW: binary index of the granted requester; 0 when `gnt_oh_o` is 0.
- `out_vld_o` output, 1: a granted requester is valid.
- `out_rdy_i` input, 1: downstream ready.

## Operation
- State registers:
  - `ptr_q` (IdxW): highest-priority index.
  - `hold_q` (1): stall lock.
  - `gnt_q` (N): held grant.
  - `pkt_q` (1): packet lock; exists only with the macro.
- Free arbitration applies when neither `hold_q` nor `pkt_q` is set:
  - Grant the first requester with `req_vld_i` set, scanning `ptr_q`, `ptr_q+1`, …, wrapping modulo N.
  - `gnt_oh_o` is that requester's bit. With no requests, `gnt_oh_o` is 0.
- Locked arbitration applies when `hold_q` or `pkt_q` is set:
  - `gnt_oh_o = gnt_q & req_vld_i`.
  - Other requests are ignored.
- `out_vld_o = |gnt_oh_o`. A handshake occurs when `out_vld_o & out_rdy_i`.
- Stall: `out_vld_o & ~out_rdy_i` sets `hold_q` and loads `gnt_q <= gnt_oh_o`.
  - `hold_q` clears on handshake.
  - `hold_q` also clears when the held requester drops valid. That drop is a protocol violation; the bench flags it with an assertion.
- Pointer update: on a handshake that ends arbitration for the granted index k, `ptr_q <= (k == N-1) ? 0 : k+1`.
  - Without the macro, every handshake ends arbitration.
  - Pointer is unchanged on stall and when idle.
- `N == 1`: `gnt_oh_o = req_vld_i`; `ptr_q` stays 0.
- Invariant: `gnt_oh_o` has at most one bit set in every cycle.

## Timing
- Reset values:
  - `ptr_q = 0`, `hold_q = 0`, `gnt_q = 0`, `pkt_q = 0`.
  - Outputs follow from state and inputs: with `req_vld_i == 0`, all outputs are 0.
- Grant latency is 0 cycles. The request-to-grant path is combinational, and `req_rdy_o` and `out_vld_o` appear in the same cycle.
- State updates on the rising `clk` edge after the qualifying cycle. The new pointer takes effect in the next cycle.
- Simultaneous events: when a new request arrives in the same cycle as a handshake, it is arbitrated against the post-update `ptr_q` in the next cycle. The current cycle's grant is unaffected.
- `rstn` asserted mid-stall or mid-packet clears all locks and the pointer immediately (asynchronous). The first grant after deassertion uses `ptr_q = 0`.

## Configuration
- Macro: `RR_ARB_PKT_LOCK_EN`.
- Defined (multi-beat packet lock):
  - A handshake with `req_last_i[k] == 0` sets `pkt_q` and loads `gnt_q`. The pointer is not updated.
  - A handshake with `req_last_i[k] == 1` clears `pkt_q` and updates `ptr_q` to k+1.
  - Single-beat packets (`last == 1` on the first beat) behave as without the macro.
- Undefined:
  - `req_last_i` is ignored and `pkt_q` is absent.
  - Every beat is arbitrated independently.

## Test plan
- Reset, then hold `req_vld_i = 8'hFF` with `out_rdy_i = 1` for 9 cycles:
  - Required `gnt_idx_o` sequence: 0,1,…,7,0.
  - `gnt_oh_o` is one-hot in each cycle.
- `req_vld_i = 8'b0000_0100` with `out_rdy_i = 0` for 3 cycles; raise bit 0 in cycle 2; then `out_rdy_i = 1`:
  - `gnt_oh_o` stays `8'h04` through the stall.
  - Handshake happens at index 2.
  - Next grant is index 0, with `ptr_q = 3` wrapping to 0.
- Requests on bits 7 and 0 after the pointer reaches 7:
  - Grant 7.
  - Next cycle, grant 0 (wrap-around).
- Macro defined; requester 3 sends beats with `last = 0,0,1` while requester 5 is continuously valid and `out_rdy_i = 1`:
  - Grants are 3,3,3, then 5.
  - Repeat with the macro undefined: grants are 3,5,3,5.
- Assert `rstn` low during a stall at index 4:
  - Outputs reflect cleared locks immediately.
  - After release, with all requests valid, the grant is index 0.
- `req_vld_i = 0`:
  - `gnt_oh_o = 0`, `gnt_idx_o = 0`, `out_vld_o = 0`, `req_rdy_o = 0`.
  - State is unchanged.

Source files
------------

// File: rtl/rr_arb_oh.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb_oh
// Purpose  : Round-robin arbiter that drives a one-hot mux select. The grant
//            is held through back-pressure, and priority rotates past the last
//            requester served. Defining RR_ARB_PKT_LOCK_EN adds a lock that
//            holds the grant for a whole multi-beat packet.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb_oh #(
    parameter int N    = 8,
    parameter int IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [N-1:0]    req_vld_i,
    input  logic [N-1:0]    req_last_i,
    output logic [N-1:0]    req_rdy_o,
    output logic [N-1:0]    gnt_oh_o,
    output logic [IdxW-1:0] gnt_idx_o,
    output logic            out_vld_o,
    input  logic            out_rdy_i
);

    logic [IdxW-1:0] ptr_q, ptr_d;
    logic            hold_q, hold_d;
    logic [N-1:0]    gnt_q, gnt_d;

    logic            w_locked;
    logic [N-1:0]    w_mask;
    logic [N-1:0]    w_hi;
    logic [N-1:0]    w_hi_first;
    logic [N-1:0]    w_all_first;
    logic [N-1:0]    w_gnt_oh;
    logic [IdxW-1:0] w_idx;
    logic [IdxW-1:0] w_ptr_nxt;
    logic            w_hs;
    logic            w_stall;
    logic            w_last;

`ifdef RR_ARB_PKT_LOCK_EN
    logic            pkt_q, pkt_d;
    assign w_locked = hold_q | pkt_q;
    assign w_last   = |(req_last_i & w_gnt_oh);
`else
    logic            w_unused_last;
    assign w_locked      = hold_q;
    assign w_last        = 1'b1;
    assign w_unused_last = ^req_last_i;
`endif

    // Lowest set bit at or above the pointer wins; otherwise wrap to the lowest set bit overall.
    assign w_mask      = {N{1'b1}} << ptr_q;
    assign w_hi        = req_vld_i & w_mask;
    assign w_hi_first  = w_hi & (~w_hi + N'(1));
    assign w_all_first = req_vld_i & (~req_vld_i + N'(1));
    assign w_gnt_oh    = w_locked ? (gnt_q & req_vld_i)
                                  : ((|w_hi) ? w_hi_first : w_all_first);

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (w_gnt_oh[i]) begin
                w_idx = w_idx | IdxW'(i);
            end
        end
    end

    assign w_hs      = out_vld_o & out_rdy_i;
    assign w_stall   = out_vld_o & ~out_rdy_i;
    assign w_ptr_nxt = (w_idx == IdxW'(N - 1)) ? '0 : w_idx + 1'b1;

    always_comb begin
        hold_d = w_stall;
        gnt_d  = gnt_q;
        ptr_d  = ptr_q;
`ifdef RR_ARB_PKT_LOCK_EN
        pkt_d  = pkt_q;
`endif
        if (w_stall) begin
            gnt_d = w_gnt_oh;
        end
        if (w_hs) begin
            if (w_last) begin
                ptr_d = w_ptr_nxt;
`ifdef RR_ARB_PKT_LOCK_EN
                pkt_d = 1'b0;
            end else begin
                pkt_d = 1'b1;
                gnt_d = w_gnt_oh;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q  <= '0;
            hold_q <= 1'b0;
            gnt_q  <= '0;
`ifdef RR_ARB_PKT_LOCK_EN
            pkt_q  <= 1'b0;
`endif
        end else begin
            ptr_q  <= ptr_d;
            hold_q <= hold_d;
            gnt_q  <= gnt_d;
`ifdef RR_ARB_PKT_LOCK_EN
            pkt_q  <= pkt_d;
`endif
        end
    end

    assign gnt_oh_o  = w_gnt_oh;
    assign gnt_idx_o = w_idx;
    assign out_vld_o = |w_gnt_oh;
    assign req_rdy_o = w_gnt_oh & {N{out_rdy_i}};

endmodule
`default_nettype wire

// File: tb/tb_rr_arb_oh.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arb_oh
// Purpose  : Directed and randomized bench for rr_arb_oh (N = 8) against a
//            scan-based reference model; honours RR_ARB_PKT_LOCK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arb_oh;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rstn;
    logic [N-1:0] req_vld;
    logic [N-1:0] req_last;
    logic [N-1:0] req_rdy;
    logic [N-1:0] gnt_oh;
    logic [2:0]   gnt_idx;
    logic         out_vld;
    logic         out_rdy;

    int checks   = 0;
    int failures = 0;

    rr_arb_oh #(.N(N)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_vld_i  (req_vld),
        .req_last_i (req_last),
        .req_rdy_o  (req_rdy),
        .gnt_oh_o   (gnt_oh),
        .gnt_idx_o  (gnt_idx),
        .out_vld_o  (out_vld),
        .out_rdy_i  (out_rdy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int           m_ptr  = 0;
    bit           m_hold = 1'b0;
    bit           m_pkt  = 1'b0;
    int           m_held = 0;
    logic [N-1:0] m_prev_stall = '0;

    function automatic int scan(logic [N-1:0] v, int p);
        for (int o = 0; o < N; o++) begin
            int i;
            i = (p + o) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        int           k;
        logic [N-1:0] e_oh;
        if (!rstn) begin
            m_ptr = 0; m_hold = 1'b0; m_pkt = 1'b0; m_held = 0; m_prev_stall = '0;
        end
        if (rstn) begin
            checks++;
            assert ((m_prev_stall & ~req_vld) == '0)
            else begin
                failures++;
                $error("FAIL protocol: held requester dropped valid, held=%h vld=%h", m_prev_stall, req_vld);
            end
        end
        if (m_hold || m_pkt) k = req_vld[m_held] ? m_held : -1;
        else                 k = scan(req_vld, m_ptr);
        e_oh = (k >= 0) ? (8'h01 << k) : 8'h00;

        checks++;
        if (gnt_oh !== e_oh || gnt_idx !== ((k >= 0) ? 3'(k) : 3'd0) ||
            out_vld !== (k >= 0) || req_rdy !== (e_oh & {N{out_rdy}})) begin
            failures++;
            $display("FAIL model t=%0t: oh=%h idx=%0d vld=%b rdy=%h, required oh=%h idx=%0d vld=%b rdy=%h",
                     $time, gnt_oh, gnt_idx, out_vld, req_rdy, e_oh,
                     (k >= 0) ? k : 0, (k >= 0), e_oh & {N{out_rdy}});
        end
        checks++;
        if (!$onehot0(gnt_oh)) begin
            failures++;
            $display("FAIL onehot t=%0t: oh=%h, required at most one bit", $time, gnt_oh);
        end

        if (rstn) begin
            m_prev_stall = out_rdy ? '0 : e_oh;
            m_hold = (k >= 0) && !out_rdy;
            if (m_hold) m_held = k;
            if (k >= 0 && out_rdy) begin
`ifdef RR_ARB_PKT_LOCK_EN
                if (!req_last[k]) begin
                    m_pkt  = 1'b1;
                    m_held = k;
                end else begin
                    m_pkt  = 1'b0;
                    m_ptr  = (k + 1) % N;
                end
`else
                m_ptr = (k + 1) % N;
`endif
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic cyc(input logic [N-1:0] v, input logic [N-1:0] l, input logic r, input logic rs);
        @(posedge clk);
        #1;
        req_vld = v; req_last = l; out_rdy = r; rstn = rs;
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input int e);
        checks++;
        if (gnt_idx !== 3'(e) || gnt_oh !== 8'(1 << e)) begin
            failures++;
            $display("FAIL %s: idx=%0d oh=%h, required idx=%0d oh=%h", nm, gnt_idx, gnt_oh, e, 8'(1 << e));
        end
    endtask

    task automatic chk_zero(input string nm);
        checks++;
        if (gnt_oh !== '0 || gnt_idx !== '0 || out_vld !== 1'b0 || req_rdy !== '0) begin
            failures++;
            $display("FAIL %s: oh=%h idx=%0d vld=%b rdy=%h, required all zero", nm, gnt_oh, gnt_idx, out_vld, req_rdy);
        end
    endtask

    int pk_exp [4];

    initial begin
        logic [N-1:0] nreq;
        rstn = 1'b0; req_vld = '0; req_last = '0; out_rdy = 1'b0;
        @(negedge clk);
        chk_zero("reset");

        for (int i = 0; i < 9; i++) begin
            cyc(8'hFF, 8'hFF, 1'b1, 1'b1);
            chk("rotate", i % 8);
        end

        cyc(8'h04, 8'hFF, 1'b0, 1'b1); chk("stall_c1", 2);
        cyc(8'h05, 8'hFF, 1'b0, 1'b1); chk("stall_c2", 2);
        cyc(8'h05, 8'hFF, 1'b0, 1'b1); chk("stall_c3", 2);
        cyc(8'h05, 8'hFF, 1'b1, 1'b1); chk("stall_hs", 2);
        cyc(8'h01, 8'hFF, 1'b1, 1'b1); chk("after_stall", 0);

        cyc(8'h40, 8'hFF, 1'b1, 1'b1); chk("to_ptr7", 6);
        cyc(8'h81, 8'hFF, 1'b1, 1'b1); chk("wrap_7", 7);
        cyc(8'h81, 8'hFF, 1'b1, 1'b1); chk("wrap_0", 0);

`ifdef RR_ARB_PKT_LOCK_EN
        pk_exp = '{3, 3, 3, 5};
`else
        pk_exp = '{3, 5, 3, 5};
`endif
        for (int b = 0; b < 4; b++) begin
            cyc(8'h28, (b == 2) ? 8'h28 : 8'h20, 1'b1, 1'b1);
            chk("packet", pk_exp[b]);
        end

        cyc(8'h10, 8'hFF, 1'b0, 1'b1); chk("rst_stall4", 4);
        cyc(8'h11, 8'hFF, 1'b0, 1'b1); chk("rst_locked", 4);
        @(posedge clk);
        #1 rstn = 1'b0;
        #1 chk("rst_immediate", 0);
        @(negedge clk);
        cyc(8'hFF, 8'hFF, 1'b1, 1'b1); chk("rst_release", 0);

        for (int i = 0; i < 3; i++) begin
            cyc(8'h00, 8'hFF, 1'b1, 1'b1);
            chk_zero("idle");
        end
        cyc(8'hFF, 8'hFF, 1'b1, 1'b1); chk("idle_ptr_kept", 1);

        for (int c = 0; c < 3000; c++) begin
            nreq = (req_vld & ~req_rdy) | (8'($urandom) & 8'($urandom));
            cyc(nreq, 8'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 399) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
